dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder on the core's data bus: services dreq/dwrite/daddr/dsize/ddata
//  and returns completion on dbusy/dready_n. Single-ported word memory with byte-lane writes
//  and a programmable wait-state count, so the core's memory-stall path (stall_Mem) is exercised.
//  Sits outside the core, attached to the same daddr/ddata/dsize/dreq/dwrite/dready_n/dbusy nets.
// PARAMETERS
//  ADDR_BITS    10  word-address width; depth = 2**ADDR_BITS 32-bit words
//  WAIT_CYCLES  2   cycles spent in BUSY before the response (0 allowed)
// PORTS
//  clk       in     1   clock, all state on rising edge
//  rst       in     1   asynchronous, active-low reset
//  dreq      in     1   request strobe from core, sampled in IDLE only
//  dwrite    in     1   1 = write, 0 = read; sampled with dreq
//  daddr     in     32  byte address; bits [ADDR_BITS+1:2] index the array, upper bits ignored (wrap)
//  dsize     in     2   00 byte, 01 half, 10 word, 11 treated as word
//  ddata     inout  32  write data in; read data out, driven only while dready_n==0 on a read
//  dready_n  out    1   active-low completion, exactly one cycle per accepted request
//  dbusy     out    1   1 from the cycle after acceptance through the dready_n cycle inclusive
//  derr      out    1   misalign error pulse (present only with DMEM_MISALIGN_CHK_EN)
// BEHAVIOUR
//  Reset (rst==0, async): state=IDLE, dready_n=1, dbusy=0, ddata=Z, derr=0, counter=0.
//    Memory contents are NOT cleared. Reset mid-operation aborts; an uncommitted write is lost.
//  FSM: IDLE -> (dreq) BUSY -> (count==WAIT_CYCLES-1) RESP -> IDLE.
//    WAIT_CYCLES==0: IDLE -> RESP directly.
//  Accept (IDLE & dreq at edge t): latch daddr, dsize, dwrite, ddata into request regs.
//    Response cycle = t+1+WAIT_CYCLES; one cycle latency floor when WAIT_CYCLES==0.
//  dreq in BUSY/RESP ignored; core must hold dreq until dready_n==0. After RESP, FSM spends
//    >=1 cycle in IDLE; back-to-back requests are accepted the cycle after RESP.
//  Write commit: on the edge entering RESP, using latched request; byte enables:
//    byte: lane daddr[1:0]; half: lanes {daddr[1],0} and {daddr[1],1}; word: all four.
//    Write data taken from low bits of latched ddata (byte [7:0], half [15:0]) and placed in lane.
//  Read: array word registered on edge entering RESP; output right-justified, zero-extended:
//    byte = word[8*a+7:8*a], half = word[16*a1+15:16*a1]; core performs sign extension.
//  Read-after-write same address: sees committed data (write commits before later read).
//  Misaligned half (daddr[0]==1) / word (daddr[1:0]!=0): without macro, low bits ignored
//    (half aligned down to 2, word aligned down to 4); access completes normally.
//  ddata tri-state: driven only in RESP of a read; Z in every other cycle, including reset.
// CONFIGURATION
//  DMEM_MISALIGN_CHK_EN defined: misaligned access still completes with dready_n==0 for one
//    cycle, but derr=1 in that same cycle, write is suppressed, read returns 32'h0.
//  Undefined: derr port absent; alignment-down behaviour above.
// STRUCTURE
//  dmem_pkg: DSIZE_BYTE/HALF/WORD constants, state encoding (IDLE/BUSY/RESP), byte-enable
//    function be_from_size(dsize, addr[1:0]).
//  Sub-module dmem_ram: synchronous 1R1W word array, 4-bit byte-enable, ADDR_BITS depth.
//  Top holds FSM, wait counter, request latches, lane steering, tri-state driver.
// TESTING
//  1 Reset: rst low mid-BUSY of a write -> dready_n=1, dbusy=0, ddata=Z at once; word unchanged.
//  2 Word write 32'hDEADBEEF @0x100, then word read @0x100 -> dready_n low at t+3 (WAIT=2),
//    ddata=32'hDEADBEEF, dbusy high exactly 3 cycles per access.
//  3 Byte write 8'h5A @0x103 over 32'h11223344 -> word read gives 32'h5A223344;
//    byte read @0x103 -> 32'h0000005A; half read @0x102 -> 32'h00005A22.
//  4 WAIT_CYCLES=0 build: back-to-back reads, dreq held high -> dready_n low every 2nd cycle,
//    never two consecutive cycles.
//  5 Address wrap (ADDR_BITS=10): write @0x1000 then read @0x0000 -> same data.
//  6 DMEM_MISALIGN_CHK_EN: word write @0x102 -> derr=1 with dready_n=0, memory unchanged;
//    half read @0x101 -> derr=1, ddata=32'h0. Without macro: half read @0x101 returns @0x100 half.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Size encodings, FSM state encoding, request payload and byte-lane helpers.
package dmem_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } dreq_t;

  // Lanes touched by an access; size 2'b11 behaves as a word.
  function automatic logic [3:0] be_from_size(input logic [1:0] dsize, input logic [1:0] addr);
    logic [3:0] be;
    case (dsize)
      DSIZE_BYTE: be = 4'b0001 << addr;
      DSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] dsize, input logic [1:0] addr);
    logic mis;
    case (dsize)
      DSIZE_BYTE: mis = 1'b0;
      DSIZE_HALF: mis = addr[0];
      default:    mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port word array with byte-lane write enables.
// Contents are never reset.
module dmem_ram #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-bus memory responder: FSM with programmable wait states, byte-lane steering, tri-state read bus.
// Optional misalignment error reporting is enabled with DMEM_MISALIGN_CHK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [1:0]  dsize,
  inout  wire  [31:0] ddata,
  output logic        dready_n,
  output logic        dbusy
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic        derr
`endif
);

  localparam int unsigned CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dreq_t            req_q, cur;
  logic             err_c;
  logic             oe_q;
  logic             enter_resp;
  logic             ram_we, ram_re;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata, rword, rdata_c;
  logic             resp_err;
  logic             unused_addr_hi;

  // In IDLE the live bus is the request; afterwards the latched copy is.
  always_comb begin
    cur = req_q;
    if (state_q == ST_IDLE) begin
      cur.write = dwrite;
      cur.size  = dsize;
      cur.addr  = daddr;
      cur.data  = ddata;
    end
  end

  assign unused_addr_hi = ^cur.addr[31:ADDR_BITS+2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign err_c    = is_misaligned(cur.size, cur.addr[1:0]);
  assign resp_err = derr;
`else
  assign err_c    = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dreq) begin
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(CNT_LAST)) state_d = ST_RESP;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      dready_n <= 1'b1;
      dbusy    <= 1'b0;
      oe_q     <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
      derr     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (state_q == ST_IDLE && dreq) req_q <= cur;
      dready_n <= (state_d != ST_RESP);
      dbusy    <= (state_d != ST_IDLE);
      oe_q     <= (state_d == ST_RESP) && !cur.write;
`ifdef DMEM_MISALIGN_CHK_EN
      derr     <= (state_d == ST_RESP) && err_c;
`endif
    end
  end

  // Memory is touched only on the edge that enters RESP.
  assign enter_resp = rst && (state_d == ST_RESP) && (state_q != ST_RESP);
  assign ram_we     = enter_resp && cur.write && !err_c;
  assign ram_re     = enter_resp && !cur.write;
  assign ram_be     = be_from_size(cur.size, cur.addr[1:0]);

  always_comb begin
    case (cur.size)
      DSIZE_BYTE: ram_wdata = {4{cur.data[7:0]}};
      DSIZE_HALF: ram_wdata = {2{cur.data[15:0]}};
      default:    ram_wdata = cur.data;
    endcase
  end

  dmem_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (cur.addr[ADDR_BITS+1:2]),
    .wdata (ram_wdata),
    .rdata (rword)
  );

  // Right-justify and zero-extend the selected lane(s).
  always_comb begin
    case (req_q.size)
      DSIZE_BYTE: rdata_c = {24'b0, rword[{req_q.addr[1:0], 3'b000} +: 8]};
      DSIZE_HALF: rdata_c = {16'b0, rword[{req_q.addr[1], 4'b0000} +: 16]};
      default:    rdata_c = rword;
    endcase
    if (resp_err) rdata_c = '0;
  end

  assign ddata = oe_q ? rdata_c : 32'bz;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a byte-level memory model.
// Build with DMEM_MISALIGN_CHK_EN defined to exercise the misalignment error path.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int WAIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dreq, dwrite, drv_en;
  logic [31:0] daddr, drv_val;
  logic [1:0]  dsize;
  wire  [31:0] ddata;
  logic        dready_n, dbusy;

  logic        dreq0, dwrite0, drv0_en;
  logic [31:0] daddr0, drv0_val;
  logic [1:0]  dsize0;
  wire  [31:0] ddata0;
  logic        dready_n0, dbusy0;
`ifdef DMEM_MISALIGN_CHK_EN
  logic        derr, derr0;
`endif

  assign ddata  = drv_en  ? drv_val  : 32'bz;
  assign ddata0 = drv0_en ? drv0_val : 32'bz;

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(WAIT)) u_dut (
    .clk(clk), .rst(rst), .dreq(dreq), .dwrite(dwrite), .daddr(daddr), .dsize(dsize),
    .ddata(ddata), .dready_n(dready_n), .dbusy(dbusy)
`ifdef DMEM_MISALIGN_CHK_EN
    , .derr(derr)
`endif
  );

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .dreq(dreq0), .dwrite(dwrite0), .daddr(daddr0), .dsize(dsize0),
    .ddata(ddata0), .dready_n(dready_n0), .dbusy(dbusy0)
`ifdef DMEM_MISALIGN_CHK_EN
    , .derr(derr0)
`endif
  );

  bit [7:0] ref_bytes [4096];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size);
`ifdef DMEM_MISALIGN_CHK_EN
    return (int'(addr[11:0]) % nbytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int base_of(input logic [31:0] addr, input logic [1:0] size);
    int a = int'(addr[11:0]);
    return a - (a % nbytes(size));
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    int b = base_of(addr, size);
    if (model_err(addr, size)) return;
    for (int i = 0; i < nbytes(size); i++) ref_bytes[b + i] = 8'(data >> (8 * i));
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] r = '0;
    int b = base_of(addr, size);
    if (model_err(addr, size)) return '0;
    for (int i = 0; i < nbytes(size); i++) r = r | (32'(ref_bytes[b + i]) << (8 * i));
    return r;
  endfunction

  // One complete bus transaction, entered and left at a falling edge.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input string tag, output logic [31:0] rd);
    int lat = 0;
    bit got = 0;
    bit busy_ok = 1;
    logic [31:0] exp = model_read(addr, size);
    bit exp_err = model_err(addr, size);
    rd = 'x;
    dreq = 1'b1; dwrite = wr; daddr = addr; dsize = size; drv_en = wr; drv_val = wdata;
    @(posedge clk);
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!dbusy) busy_ok = 0;
      if (!dready_n) got = 1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WAIT + 1));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    if (got) begin
      rd = ddata;
      if (wr) check({tag, "_bus_hold"}, ddata, wdata);
      else    check({tag, "_rdata"}, ddata, exp);
`ifdef DMEM_MISALIGN_CHK_EN
      check({tag, "_derr"}, 32'(derr), 32'(exp_err));
`else
      if (exp_err) check({tag, "_err_model"}, 32'd1, 32'd0);
`endif
    end
    if (wr) model_write(addr, size, wdata);
    dreq = 1'b0; dwrite = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    check({tag, "_ready_off"}, 32'(dready_n), 32'd1);
    check({tag, "_busy_off"}, 32'(dbusy), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, w0;
    int lat0, lows, consec;
    bit prev_low, exp_low;

    rst = 1'b0; dreq = 1'b0; dwrite = 1'b0; daddr = '0; dsize = '0; drv_en = 1'b0; drv_val = '0;
    dreq0 = 1'b0; dwrite0 = 1'b0; daddr0 = '0; dsize0 = '0; drv0_en = 1'b0; drv0_val = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(dready_n), 32'd1);
    check("reset_busy", 32'(dbusy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fill the working window so every later read has a known value.
    for (int i = 0; i < 16; i++) access(1'b1, 32'h100 + 32'(4 * i), 2'b10, $urandom, "init", rd);

    access(1'b1, 32'h100, 2'b10, 32'hDEADBEEF, "t2_wr", rd);
    access(1'b0, 32'h100, 2'b10, 32'h0, "t2_rd", rd);
    check("t2_const", rd, 32'hDEADBEEF);

    access(1'b1, 32'h100, 2'b10, 32'h11223344, "t3_wr", rd);
    access(1'b1, 32'h103, 2'b00, 32'hFFFFFF5A, "t3_wrb", rd);
    access(1'b0, 32'h100, 2'b10, 32'h0, "t3_rdw", rd);
    check("t3_word_const", rd, 32'h5A223344);
    access(1'b0, 32'h103, 2'b00, 32'h0, "t3_rdb", rd);
    check("t3_byte_const", rd, 32'h0000005A);
    access(1'b0, 32'h102, 2'b01, 32'h0, "t3_rdh", rd);
    check("t3_half_const", rd, 32'h00005A22);

    access(1'b1, 32'h1000, 2'b10, 32'h0BADF00D, "t5_wr", rd);
    access(1'b0, 32'h0000, 2'b10, 32'h0, "t5_rd", rd);
    check("t5_wrap_const", rd, 32'h0BADF00D);

    access(1'b0, 32'h101, 2'b01, 32'h0, "t6_rdh", rd);
`ifdef DMEM_MISALIGN_CHK_EN
    check("t6_half_const", rd, 32'h0);
`else
    check("t6_half_const", rd, 32'h00003344);
`endif
    access(1'b1, 32'h102, 2'b10, 32'hFFFF0000, "t6_wrw", rd);
    access(1'b0, 32'h100, 2'b10, 32'h0, "t6_rdw", rd);
`ifdef DMEM_MISALIGN_CHK_EN
    check("t6_word_const", rd, 32'h5A223344);
`else
    check("t6_word_const", rd, 32'hFFFF0000);
`endif

    // Reset in the middle of a write's wait states: response aborted, word untouched.
    dreq = 1'b1; dwrite = 1'b1; daddr = 32'h104; dsize = 2'b10; drv_en = 1'b1; drv_val = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    check("t1_busy_before", 32'(dbusy), 32'd1);
    rst = 1'b0;
    #1;
    check("t1_ready_reset", 32'(dready_n), 32'd1);
    check("t1_busy_reset", 32'(dbusy), 32'd0);
    dreq = 1'b0; dwrite = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, 32'h104, 2'b10, 32'h0, "t1_rd", rd);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a = 32'h100 + 32'($urandom_range(0, 63)) + 32'h1000 * 32'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom, "rand", rd);
    end

    // Zero-wait instance: 1-cycle latency, responses on alternate cycles with dreq held.
    w0 = $urandom;
    dreq0 = 1'b1; dwrite0 = 1'b1; daddr0 = 32'h40; dsize0 = 2'b10; drv0_en = 1'b1; drv0_val = w0;
    @(posedge clk);
    lat0 = 0;
    do begin
      @(negedge clk);
      lat0++;
    end while (dready_n0 && lat0 < 8);
    check("t4_wr_latency", 32'(lat0), 32'd1);
    dreq0 = 1'b0; dwrite0 = 1'b0; drv0_en = 1'b0;
    @(negedge clk);
    dreq0 = 1'b1;
    lows = 0; consec = 0; prev_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_low = (i % 2) == 0;
      check("t4_ready", 32'(dready_n0), 32'(!exp_low));
      check("t4_busy", 32'(dbusy0), 32'(exp_low));
      if (!dready_n0) begin
        lows++;
        if (prev_low) consec++;
        check("t4_rdata", ddata0, w0);
      end
      prev_low = !dready_n0;
    end
    check("t4_low_count", 32'(lows), 32'd10);
    check("t4_consecutive", 32'(consec), 32'd0);
    dreq0 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
